// File: rtl/regdump_ctrl.sv
// End-of-run register dump sequencer: runs the processor for NUM_CYCLES clocks,
// halts it, then walks regfile read port A and streams each register out over valid/ready.
module regdump_ctrl #(
    parameter int NUM_CYCLES = 255,
    parameter int REG_COUNT  = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        cpu_rs1,
    input  logic [DATA_W-1:0] regA,
    output logic [4:0]        rs1_out,
    output logic              cpu_halt,
    output logic              test_mode,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done
);

    // Counter must hold NUM_CYCLES itself, since it still ticks on the RUN->READ edge.
    localparam int CNT_W      = (NUM_CYCLES > 0) ? $clog2(NUM_CYCLES + 1) : 1;
    localparam int CNT_LAST_I = (NUM_CYCLES > 0) ? NUM_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [4:0]       IDX_LAST = 5'(REG_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_READ,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (NUM_CYCLES > 0) ? S_RUN : S_READ;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (dump_ready) begin
                    state_d = (idx_q == IDX_LAST) ? S_DONE : S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset releases port A at once.
    always_comb begin
        cpu_halt   = 1'b1;
        test_mode  = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_RUN: begin
                cpu_halt = 1'b0;
                busy     = 1'b1;
            end
            S_READ: begin
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            S_PRESENT: begin
                test_mode  = 1'b1;
                dump_valid = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                cpu_halt = 1'b1;
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        data_d = data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_READ: begin
                data_d = regA;
            end
            S_PRESENT: begin
                if (dump_ready && (idx_q != IDX_LAST)) begin
                    idx_d = idx_q + 5'd1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign rs1_out   = test_mode ? idx_q : cpu_rs1;
    assign dump_idx  = idx_q;
    assign dump_data = data_q;

endmodule

// File: tb/tb_regdump_ctrl.sv
// Bench for regdump_ctrl: cycle table for the opening sequence, then transaction-level
// runs against an expected (idx, data) queue with random backpressure, start pulses and mux inputs.
module tb_regdump_ctrl;

    localparam int N  = 4;
    localparam int RC = 32;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          start_a, start_b;
    logic [4:0]    cpu_rs1;
    logic          dump_ready;
    logic [DW-1:0] regs [RC];

    logic [4:0]    rs1_a, idx_a, rs1_b, idx_b;
    logic          halt_a, tm_a, vld_a, busy_a, done_a;
    logic          halt_b, tm_b, vld_b, busy_b, done_b;
    logic [DW-1:0] data_a, data_b, regA_a, regA_b;

    assign regA_a = regs[rs1_a];
    assign regA_b = regs[rs1_b];

    regdump_ctrl #(.NUM_CYCLES(N), .REG_COUNT(RC), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start_a), .cpu_rs1(cpu_rs1), .regA(regA_a),
        .rs1_out(rs1_a), .cpu_halt(halt_a), .test_mode(tm_a), .dump_valid(vld_a),
        .dump_ready(dump_ready), .dump_idx(idx_a), .dump_data(data_a), .busy(busy_a), .done(done_a)
    );

    regdump_ctrl #(.NUM_CYCLES(0), .REG_COUNT(RC), .DATA_W(DW)) dut0 (
        .clock(clock), .reset(reset), .start(start_b), .cpu_rs1(cpu_rs1), .regA(regA_b),
        .rs1_out(rs1_b), .cpu_halt(halt_b), .test_mode(tm_b), .dump_valid(vld_b),
        .dump_ready(dump_ready), .dump_idx(idx_b), .dump_data(data_b), .busy(busy_b), .done(done_b)
    );

    logic          sel_b;
    logic          s_halt, s_tm, s_vld, s_busy, s_done;
    logic [4:0]    s_rs1, s_idx;
    logic [DW-1:0] s_data;
    always_comb begin
        s_halt = sel_b ? halt_b : halt_a;
        s_tm   = sel_b ? tm_b   : tm_a;
        s_vld  = sel_b ? vld_b  : vld_a;
        s_busy = sel_b ? busy_b : busy_a;
        s_done = sel_b ? done_b : done_a;
        s_rs1  = sel_b ? rs1_b  : rs1_a;
        s_idx  = sel_b ? idx_b  : idx_a;
        s_data = sel_b ? data_b : data_a;
    end

    typedef struct {
        logic       st;
        logic [4:0] rs1;
        logic       rdy;
        logic       halt;
        logic       tm;
        logic       vld;
        logic       busy;
        logic       done;
        logic [4:0] rs1o;
        logic [4:0] idx;
    } vec_t;
    vec_t vt [11];

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One full start..done transaction; the model only knows the run length and the
    // READ->PRESENT->accept rhythm of each register transfer.
    // mode 0: ready high; 1: ready low 5 cycles on idx 3; 2: random ready + start pulses.
    task automatic run_dump(input int mode, input bit use_b, input int ncyc);
        logic [4:0]    q_idx [$];
        logic [DW-1:0] q_dat [$];
        int  c;
        int  bp_left;
        bit  fin;
        bit  ev;
        bit  tm_e;
        sel_b = use_b;
        for (int i = 0; i < RC; i++) begin
            q_idx.push_back(5'(i));
            q_dat.push_back(regs[i]);
        end
        @(negedge clock);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        dump_ready = 1'b1;
        c = 1; fin = 1'b0; ev = 1'b0; bp_left = 5;
        while (1) begin
            @(negedge clock);
            start_a = 1'b0;
            start_b = 1'b0;
            if (mode == 2 && !fin && $urandom_range(0, 7) == 0) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            cpu_rs1 = 5'($urandom);
            #1;
            tm_e = (c > ncyc) && !fin;
            if (mode == 1 && ev && q_idx[0] == 5'd3 && bp_left > 0) begin
                dump_ready = 1'b0;
                bp_left--;
            end else if (mode == 2) begin
                dump_ready = ($urandom_range(0, 2) != 0);
            end else begin
                dump_ready = 1'b1;
            end
            #1;
            chk($sformatf("c%0d_halt", c), 32'(s_halt), 32'(c > ncyc));
            chk($sformatf("c%0d_busy", c), 32'(s_busy), 32'(!fin));
            chk($sformatf("c%0d_done", c), 32'(s_done), 32'(fin));
            chk($sformatf("c%0d_tmode", c), 32'(s_tm), 32'(tm_e));
            chk($sformatf("c%0d_valid", c), 32'(s_vld), 32'(ev));
            chk($sformatf("c%0d_rs1out", c), 32'(s_rs1), tm_e ? 32'(q_idx[0]) : 32'(cpu_rs1));
            if (ev) begin
                chk($sformatf("c%0d_idx", c), 32'(s_idx), 32'(q_idx[0]));
                chk($sformatf("c%0d_data", c), s_data, q_dat[0]);
            end
            if (fin) begin
                chk("done_idx", 32'(s_idx), 32'(RC - 1));
                break;
            end
            if (c > ncyc) begin
                if (ev) begin
                    if (dump_ready) begin
                        void'(q_idx.pop_front());
                        void'(q_dat.pop_front());
                        ev = 1'b0;
                        if (q_idx.size() == 0) fin = 1'b1;
                    end
                end else begin
                    ev = 1'b1;
                end
            end
            c++;
            if (c > ncyc + 20 * RC + 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL run_timeout: got no done after %0d cycles, want done", c);
                break;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        int found;
        n_cmp = 0;
        n_bad = 0;
        sel_b = 1'b0;
        for (int i = 0; i < RC; i++) regs[i] = $urandom;
        regs[5] = 32'hDEADBEEF;
        vt[0]  = '{1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0};
        vt[1]  = '{1'b1, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0};
        vt[2]  = '{1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0};
        vt[3]  = '{1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 5'd0};
        vt[4]  = '{1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0};
        vt[5]  = '{1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0};
        vt[6]  = '{1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0};
        vt[7]  = '{1'b0, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0};
        vt[8]  = '{1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0};
        vt[9]  = '{1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd1};
        vt[10] = '{1'b0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1};

        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; cpu_rs1 = 5'd3; dump_ready = 1'b0;
        #1;
        chk("rst_halt", 32'(halt_a), 32'd1);
        chk("rst_tmode", 32'(tm_a), 32'd0);
        chk("rst_valid", 32'(vld_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_rs1out", 32'(rs1_a), 32'd3);
        chk("rst_halt_b", 32'(halt_b), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Opening cycles: idle, start, RUN of N clocks with an ignored start, first transfers.
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            start_a = vt[i].st; cpu_rs1 = vt[i].rs1; dump_ready = vt[i].rdy;
            #1;
            chk($sformatf("row%0d_halt", i), 32'(halt_a), 32'(vt[i].halt));
            chk($sformatf("row%0d_tmode", i), 32'(tm_a), 32'(vt[i].tm));
            chk($sformatf("row%0d_valid", i), 32'(vld_a), 32'(vt[i].vld));
            chk($sformatf("row%0d_busy", i), 32'(busy_a), 32'(vt[i].busy));
            chk($sformatf("row%0d_done", i), 32'(done_a), 32'(vt[i].done));
            chk($sformatf("row%0d_rs1out", i), 32'(rs1_a), 32'(vt[i].rs1o));
            chk($sformatf("row%0d_idx", i), 32'(idx_a), 32'(vt[i].idx));
            if (vt[i].vld) chk($sformatf("row%0d_data", i), data_a, regs[vt[i].idx]);
        end
        start_a = 1'b0;

        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        run_dump(0, 1'b0, N);
        run_dump(1, 1'b0, N);
        @(negedge clock); cpu_rs1 = 5'd19; #1;
        chk("done_rs1out", 32'(rs1_a), 32'd19);
        chk("done_hold", 32'(done_a), 32'd1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < RC; i++) regs[i] = $urandom;
            run_dump(2, 1'b0, N);
        end

        // Reset landing in PRESENT at idx 10 must release port A without a clock edge.
        @(negedge clock); start_a = 1'b1; dump_ready = 1'b1;
        @(negedge clock); start_a = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (vld_a && idx_a == 5'd10) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        chk("reach_idx10", 32'(found), 32'd1);
        cpu_rs1 = 5'd7;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(vld_a), 32'd0);
        chk("arst_tmode", 32'(tm_a), 32'd0);
        chk("arst_rs1out", 32'(rs1_a), 32'd7);
        chk("arst_halt", 32'(halt_a), 32'd1);
        chk("arst_idx", 32'(idx_a), 32'd0);
        @(negedge clock); reset = 1'b1; #1;
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_done", 32'(done_a), 32'd0);
        run_dump(0, 1'b0, N);

        run_dump(0, 1'b1, 0);
        for (int i = 0; i < RC; i++) regs[i] = $urandom;
        run_dump(2, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regdump_ctrl.md
Name: regdump_ctrl

Overview:
- Sequences end-of-run register verification for the processor/regfile pair.
- Lets the processor run for a programmed number of cycles, then halts it and takes over regfile read port A.
- Walks registers 0..REG_COUNT-1 and streams each value out over a valid/ready interface.
- Sits between processor and regfile on the read-A address path; replaces the bench-side port hijack with synthesizable logic.

Parameters:
- NUM_CYCLES, 255: processor run length in clocks before dump; 0 means dump immediately.
- REG_COUNT, 32: number of registers dumped (1..32).
- DATA_W, 32: register data width.

Ports:
- clock  in  1: system clock, all state on rising edge.
- reset  in  1: asynchronous, active-low reset.
- start  in  1: begin run; sampled only in IDLE or DONE.
- cpu_rs1  in  5: processor read-A register address.
- regA  in  DATA_W: regfile read-A data (combinational read).
- rs1_out  out  5: address to regfile read A; equals dump_idx when test_mode=1, else cpu_rs1 (combinational mux).
- cpu_halt  out  1: holds processor (clock-enable low) while 1.
- test_mode  out  1: 1 while the controller owns read port A.
- dump_valid  out  1: dump_idx/dump_data valid.
- dump_ready  in  1: consumer accepts on valid&&ready.
- dump_idx  out  5: register index being presented.
- dump_data  out  DATA_W: captured register value.
- busy  out  1: 1 in any state except IDLE and DONE.
- done  out  1: 1 in DONE.

Behaviour:
- States: IDLE, RUN, READ, PRESENT, DONE.
- Reset (reset=0, async): state=IDLE, cycle counter=0, dump_idx=0, dump_data=0, all 1-bit outputs 0, cpu_halt=1.
  - Processor is held until start.
- IDLE/DONE + start=1:
  - If NUM_CYCLES>0: RUN with counter=0, cpu_halt=0.
  - If NUM_CYCLES==0: READ directly with cpu_halt=1.
  - In both cases dump_idx is cleared to 0 and done drops the next cycle.
- RUN:
  - Counter increments each clock.
  - In the cycle counter==NUM_CYCLES-1, next state is READ and cpu_halt rises with the transition.
  - Processor therefore receives exactly NUM_CYCLES un-halted clocks. Counter width is clog2(NUM_CYCLES+1), and it never wraps.
- test_mode=1 in READ and PRESENT only; cpu_halt=1 in every state except RUN.
- READ (one cycle):
  - rs1_out=dump_idx.
  - On the clock edge, dump_data<=regA; next state PRESENT.
- PRESENT:
  - dump_valid=1, with dump_idx and dump_data held stable until the handshake.
  - On valid&&ready:
    - If dump_idx==REG_COUNT-1: go to DONE, dump_valid drops.
    - Else: dump_idx increments and state returns to READ.
  - Minimum 2 clocks per register with ready tied high; 2*REG_COUNT clocks for a full dump.
- Backpressure: dump_ready=0 holds PRESENT indefinitely with no data change; valid is never withdrawn before acceptance.
- DONE: done=1, cpu_halt=1, test_mode=0, dump_idx holds REG_COUNT-1. A new start re-runs the whole sequence.
- start while busy: ignored, with no restart and no counter disturbance.
- Simultaneous start and reset: reset wins.
- Reset mid-RUN or mid-dump: immediate return to IDLE; test_mode and dump_valid drop asynchronously, returning read port A to the processor.
- Regfile writes are not gated by this block; the processor is halted so no writes occur during the dump.

Test Plan:
- NUM_CYCLES=4, start pulse, dump_ready=1:
  - cpu_halt low for exactly 4 clocks.
  - 32 accepted transfers with dump_idx 0..31 in order and dump_data matching preloaded regfile values (r5=0xDEADBEEF).
  - done=1 two clocks after the last READ entry; 64 dump clocks in total.
- NUM_CYCLES=0: start -> READ the next cycle, cpu_halt never low, first dump_valid 2 clocks after start.
- Backpressure, dump_ready low 5 cycles during idx=3:
  - dump_valid stays 1 and idx/data stay stable.
  - Exactly one transfer per idx; no skips or duplicates.
- start pulsed during RUN at counter=2: ignored, and RUN length is still NUM_CYCLES.
- reset asserted in PRESENT at idx=10:
  - dump_valid and test_mode go 0 without waiting for a clock.
  - After release, state is IDLE; a new start dumps from idx 0.
- Port mux:
  - In RUN, cpu_rs1=7 -> rs1_out=7.
  - In READ with idx=12 and cpu_rs1=7 -> rs1_out=12.
  - In DONE -> rs1_out=cpu_rs1.
